// File: rtl/alu_pkg.sv
// Shared op encodings, FSM state encoding and op classification for alu_mdu.
package alu_pkg;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_NOR   = 4'd5;
   localparam logic [3:0] OP_SLL   = 4'd6;
   localparam logic [3:0] OP_SRL   = 4'd7;
   localparam logic [3:0] OP_SRA   = 4'd8;
   localparam logic [3:0] OP_SLT   = 4'd9;
   localparam logic [3:0] OP_SLTU  = 4'd10;
   localparam logic [3:0] OP_MULT  = 4'd11;
   localparam logic [3:0] OP_MULTU = 4'd12;
   localparam logic [3:0] OP_DIV   = 4'd13;
   localparam logic [3:0] OP_DIVU  = 4'd14;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   function automatic logic is_iter_op(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative multiply/divide engine: one shift-add or restoring-divide step per cycle,
// on operand magnitudes, with the sign fix-up folded into the final step.
module muldiv_core import alu_pkg::*; #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output state_t           state
);

   state_t               state_q, state_d;
   logic [SHAMT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]     acc_q, acc_d, mq_q, mq_d, md_q, md_d;
   logic                 is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

   logic                 signed_op, a_neg, b_neg, op_div;
   logic [WIDTH-1:0]     mag_a, mag_b, mul_add, acc_step, mq_step;
   logic [WIDTH:0]       mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0]   prod_fix;

   always_comb begin
      signed_op = (op == OP_MULT) || (op == OP_DIV);
      op_div    = (op == OP_DIV) || (op == OP_DIVU);
      a_neg     = signed_op & a[WIDTH-1];
      b_neg     = signed_op & b[WIDTH-1];
      mag_a     = a_neg ? -a : a;
      mag_b     = b_neg ? -b : b;

      // {acc,mq} is the product register for multiply, {remainder,dividend/quotient} for divide
      mul_add   = mq_q[0] ? md_q : '0;
      mul_sum   = {1'b0, acc_q} + {1'b0, mul_add};
      div_shift = {acc_q, mq_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, md_q};
      if (is_div_q) begin
         acc_step = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
         mq_step  = {mq_q[WIDTH-2:0], ~div_diff[WIDTH]};
      end else begin
         acc_step = mul_sum[WIDTH:1];
         mq_step  = {mul_sum[0], mq_q[WIDTH-1:1]};
      end
      prod_fix  = neg_res_q ? -{acc_step, mq_step} : {acc_step, mq_step};

      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mq_d      = mq_q;
      md_d      = md_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         ST_RUN: begin
            acc_d = acc_step;
            mq_d  = mq_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
               state_d = ST_DONE;
               if (is_div_q) begin
                  lo_d = neg_res_q ? -mq_step : mq_step;
                  hi_d = neg_rem_q ? -acc_step : acc_step;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            if (start) begin
               state_d   = ST_RUN;
               cnt_d     = '0;
               acc_d     = '0;
               is_div_d  = op_div;
               mq_d      = op_div ? mag_a : mag_b;
               md_d      = op_div ? mag_b : mag_a;
               // Divide by zero keeps an all-ones quotient, so no quotient negate then
               neg_res_d = (a_neg ^ b_neg) & (~op_div | (b != '0));
               neg_rem_d = a_neg;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mq_q      <= '0;
         md_q      <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mq_q      <= mq_d;
         md_q      <= md_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy  = (state_q == ST_RUN);
   assign done  = (state_q == ST_DONE);
   assign hi    = hi_q;
   assign lo    = lo_q;
   assign state = state_q;

endmodule

// File: rtl/alu_mdu.sv
// Single-cycle ALU plus iterative multiply/divide unit sharing one start/busy/done handshake.
// Handshake: start is accepted on a rising edge whenever busy is low; done pulses for one cycle.
module alu_mdu import alu_pkg::*; #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo,
   output logic               busy,
   output logic               done,
   output state_t             dbg_state
);

   logic [WIDTH-1:0] result_q, result_d, alu_res;
   logic             zero_q, zero_d, sc_done_q, sc_done_d;
   logic             accept, core_busy, core_done;

   assign accept = start & ~core_busy;

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_SLL:  alu_res = b << shamt;
         OP_SRL:  alu_res = b >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(b) >>> shamt);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
         default: alu_res = '0;
      endcase

      result_d  = result_q;
      zero_d    = zero_q;
      sc_done_d = 1'b0;
      // Iterative ops leave result/zero untouched; reserved codes complete as result 0
      if (accept && !is_iter_op(op)) begin
         result_d  = alu_res;
         zero_d    = (alu_res == '0);
         sc_done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q  <= '0;
         zero_q    <= 1'b1;
         sc_done_q <= 1'b0;
      end else begin
         result_q  <= result_d;
         zero_q    <= zero_d;
         sc_done_q <= sc_done_d;
      end
   end

   muldiv_core #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_core (
      .clk   (clk),
      .rst   (rst),
      .start (accept & is_iter_op(op)),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (core_busy),
      .done  (core_done),
      .hi    (hi),
      .lo    (lo),
      .state (dbg_state)
   );

   assign result = result_q;
   assign zero   = zero_q;
   assign busy   = core_busy;
   assign done   = sc_done_q | core_done;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu at WIDTH=32: vector tables, scoreboard queue, corner sequences.
module tb_alu_mdu;
   import alu_pkg::*;

   localparam int W = 32;

   logic          clk, rst, start;
   logic [3:0]    op_i;
   logic [W-1:0]  a_i, b_i;
   logic [4:0]    sh_i;
   logic [W-1:0]  result, hi, lo;
   logic          zero, busy, done;
   state_t        dbg_state;

   int tests, fails;
   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] last_hilo;
   logic [W-1:0]   last_result;

   typedef struct {
      logic [3:0]     op;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [4:0]     sh;
      logic [2*W-1:0] exp;
   } vec_t;

   vec_t it_tab[$];
   vec_t sc_tab[$];

   alu_mdu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op_i), .a(a_i), .b(b_i), .shamt(sh_i),
      .result(result), .zero(zero), .hi(hi), .lo(lo), .busy(busy), .done(done),
      .dbg_state(dbg_state)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [2*W-1:0] model_md(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      longint p;
      int     sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      case (o)
         OP_MULTU: return {32'd0, x} * {32'd0, y};
         OP_MULT: begin
            p = longint'(sx) * longint'(sy);
            return p;
         end
         OP_DIVU: return (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
         default: begin
            if (y == 0) return {x, 32'hFFFFFFFF};
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, x};
            return {32'(sx % sy), 32'(sx / sy)};
         end
      endcase
   endfunction

   // driver: one-cycle start pulse, operands scrambled right after acceptance
   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [4:0] s, input logic [2*W-1:0] e, input bit now);
      exp_q.push_back(e);
      if (!now) begin
         @(negedge clk);
         check("done_single_pulse", {63'd0, done}, 64'd0);
      end
      start = 1'b1; op_i = o; a_i = x; b_i = y; sh_i = s;
      @(negedge clk);
      start = 1'b0;
      a_i = $urandom; b_i = $urandom; sh_i = 5'($urandom_range(0, 31));
      op_i = 4'($urandom_range(0, 15));
   endtask

   // monitor: wait (bounded) for done, pop expectation, compare
   task automatic collect(input bit iter, input string name, input int cyc0);
      int             cyc;
      bit             busy_ok;
      logic [2*W-1:0] e;
      cyc = cyc0;
      busy_ok = 1'b1;
      while (!done && cyc < 200) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: no done after %0d cycles, required done", name, cyc);
         return;
      end
      if (iter) begin
         check({name, "_hi"}, {32'd0, hi}, {32'd0, e[2*W-1:W]});
         check({name, "_lo"}, {32'd0, lo}, {32'd0, e[W-1:0]});
         check({name, "_latency"}, 64'(cyc), 64'd32);
         check({name, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
         check({name, "_busy_done"}, {63'd0, busy}, 64'd0);
         check({name, "_result_held"}, {32'd0, result}, {32'd0, last_result});
         last_hilo = e;
      end else begin
         check({name, "_result"}, {32'd0, result}, {32'd0, e[W-1:0]});
         check({name, "_zero"}, {63'd0, zero}, {63'd0, e[W-1:0] == '0});
         check({name, "_hilo_held"}, {hi, lo}, last_hilo);
         check({name, "_latency"}, 64'(cyc), 64'd0);
         last_result = e[W-1:0];
      end
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_result"}, {32'd0, result}, 64'd0);
      check({name, "_zero"}, {63'd0, zero}, 64'd1);
      check({name, "_hi"}, {32'd0, hi}, 64'd0);
      check({name, "_lo"}, {32'd0, lo}, 64'd0);
      check({name, "_busy"}, {63'd0, busy}, 64'd0);
      check({name, "_done"}, {63'd0, done}, 64'd0);
      check({name, "_state"}, {62'd0, dbg_state}, {62'd0, ST_IDLE});
   endtask

   initial begin
      int nd;
      logic [3:0]   o;
      logic [W-1:0] x, y;

      tests = 0; fails = 0;
      last_hilo = '0; last_result = '0;
      rst = 1'b1; start = 1'b0; op_i = '0; a_i = '0; b_i = '0; sh_i = '0;

      it_tab.push_back('{OP_MULT,  32'hFFFFFFFD, 32'd7,        5'd0, 64'hFFFFFFFF_FFFFFFEB});
      it_tab.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd2,        5'd0, 64'hFFFFFFFF_FFFFFFFD});
      it_tab.push_back('{OP_DIVU,  32'd9,        32'd0,        5'd0, 64'h00000009_FFFFFFFF});
      it_tab.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 5'd0, 64'h00000000_80000000});
      it_tab.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd0,        5'd0, 64'hFFFFFFF9_FFFFFFFF});
      it_tab.push_back('{OP_DIV,   32'd7,        32'hFFFFFFFE, 5'd0, 64'h00000001_FFFFFFFD});
      it_tab.push_back('{OP_MULT,  32'h80000000, 32'h80000000, 5'd0, 64'h40000000_00000000});
      it_tab.push_back('{OP_DIVU,  32'd100,      32'd7,        5'd0, 64'h00000002_0000000E});

      sc_tab.push_back('{OP_SUB,  32'd5,        32'd5,        5'd0,  64'h0});
      sc_tab.push_back('{OP_ADD,  32'hFFFFFFFF, 32'd1,        5'd0,  64'h0});
      sc_tab.push_back('{OP_ADD,  32'd2,        32'd3,        5'd0,  64'h5});
      sc_tab.push_back('{OP_SUB,  32'd3,        32'd5,        5'd0,  64'hFFFFFFFE});
      sc_tab.push_back('{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  64'hF000F000});
      sc_tab.push_back('{OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  64'hFFF0FFF0});
      sc_tab.push_back('{OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  64'h0FF00FF0});
      sc_tab.push_back('{OP_NOR,  32'd0,        32'd0,        5'd0,  64'hFFFFFFFF});
      sc_tab.push_back('{OP_SLL,  32'd0,        32'd1,        5'd31, 64'h80000000});
      sc_tab.push_back('{OP_SRL,  32'd0,        32'h80000000, 5'd31, 64'h1});
      sc_tab.push_back('{OP_SRA,  32'd0,        32'h80000000, 5'd4,  64'hF8000000});
      sc_tab.push_back('{OP_SRA,  32'd0,        32'h40000000, 5'd4,  64'h04000000});
      sc_tab.push_back('{OP_SLT,  32'hFFFFFFFF, 32'd1,        5'd0,  64'h1});
      sc_tab.push_back('{OP_SLT,  32'd5,        32'd5,        5'd0,  64'h0});
      sc_tab.push_back('{OP_SLTU, 32'hFFFFFFFF, 32'd1,        5'd0,  64'h0});
      sc_tab.push_back('{OP_SLTU, 32'd1,        32'hFFFFFFFF, 5'd0,  64'h1});
      sc_tab.push_back('{4'd15,   32'd1,        32'd2,        5'd0,  64'h0});

      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      foreach (it_tab[i]) begin
         issue(it_tab[i].op, it_tab[i].a, it_tab[i].b, it_tab[i].sh, it_tab[i].exp, 1'b0);
         collect(1'b1, $sformatf("it%0d", i), 0);
      end
      foreach (sc_tab[i]) begin
         issue(sc_tab[i].op, sc_tab[i].a, sc_tab[i].b, sc_tab[i].sh, sc_tab[i].exp, 1'b0);
         collect(1'b0, $sformatf("sc%0d", i), 0);
      end

      // starts issued in the DONE cycle are accepted
      issue(OP_DIVU, 32'd100, 32'd7, 5'd0, 64'h00000002_0000000E, 1'b0);
      collect(1'b1, "divu_pre", 0);
      issue(OP_ADD, 32'd4, 32'd4, 5'd0, 64'h8, 1'b1);
      collect(1'b0, "add_in_done", 0);
      issue(OP_DIV, 32'hFFFFFF9C, 32'd7, 5'd0, model_md(OP_DIV, 32'hFFFFFF9C, 32'd7), 1'b0);
      collect(1'b1, "div_neg100", 0);
      issue(OP_MULTU, 32'd6, 32'd7, 5'd0, 64'd42, 1'b1);
      collect(1'b1, "multu_in_done", 0);

      // starts pulsed while busy are ignored: one done, result untouched
      issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 64'hFFFFFFFE_00000001, 1'b0);
      nd = 0;
      for (int i = 1; i <= 6; i++) begin
         start = i[0]; op_i = OP_ADD; a_i = 32'(i); b_i = 32'd1;
         @(negedge clk);
         if (done) nd++;
      end
      start = 1'b0;
      collect(1'b1, "multu_busy", 6);
      repeat (40) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("multu_extra_done", 64'(nd), 64'd0);

      for (int i = 0; i < 8; i++) begin
         o = 4'(11 + $urandom_range(0, 3));
         x = $urandom;
         y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         issue(o, x, y, 5'd0, model_md(o, x, y), 1'b0);
         collect(1'b1, $sformatf("rnd%0d", i), 0);
      end

      // reset in the middle of a divide abandons it
      issue(OP_DIVU, 32'd1000, 32'd7, 5'd0, 64'd0, 1'b0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      start = 1'b1; op_i = OP_ADD; a_i = 32'd9; b_i = 32'd9;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check_reset_state("mid_rst");
      exp_q.delete();
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("mid_rst_no_done", 64'(nd), 64'd0);
      last_result = '0;
      last_hilo = '0;
      issue(OP_ADD, 32'd2, 32'd3, 5'd0, 64'd5, 1'b0);
      collect(1'b0, "add_after_rst", 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
